ts_gen_mlane: RTL and testbench

- Parametrised multi-lane training-set generator; successor to the per-lane single-instance TS generator.
- One instance drives all NUM_LANES lanes in lockstep and builds TS1/TS2 symbols per lane, including the lane number.
- Paces emission by current link speed and counts TSs sent so core_fsm can detect "sent enough".
- Sits between core_fsm and the per-lane TX FIFOs.

---
 rtl/ts_gen_mlane_if.sv | 21 ++
 rtl/ts_gen_mlane.sv | 159 +++++++++++++++
 tb/tb_ts_gen_mlane.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_gen_mlane_if.sv
// TX-side bus between the multi-lane TS generator and the per-lane TX FIFOs.
// master: drives ts_o / ts_o_vld, samples tx_fifo_full; slave: the FIFO side.
interface ts_gen_mlane_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES*128-1:0] ts_o;
    logic [NUM_LANES-1:0]     ts_o_vld;
    logic [NUM_LANES-1:0]     tx_fifo_full;

    modport master (
        output ts_o,
        output ts_o_vld,
        input  tx_fifo_full
    );

    modport slave (
        input  ts_o,
        input  ts_o_vld,
        output tx_fifo_full
    );
endinterface

// File: rtl/ts_gen_mlane.sv
// Multi-lane TS1/TS2 generator: all lanes in lockstep, speed-paced, counts TSs.
// Ports: clk, rst (async active-low), config inputs from core_fsm, tx bus, count/flag/busy.
module ts_gen_mlane #(
    parameter int NUM_LANES   = 4,
    parameter int CNT_W       = 16,
    parameter int GEN1_PERIOD = 64,
    parameter int MAX_GEN     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           ts_info,
    input  logic                 ts_type,
    input  logic [7:0]           link_num,
    input  logic [2:0]           speed,
    input  logic [NUM_LANES-1:0] lane_en,
    input  logic [CNT_W-1:0]     sent_target,
    input  logic                 ts_update,
    input  logic                 ts_stop,
    ts_gen_mlane_if.master       tx,
    output logic [CNT_W-1:0]     ts_sent_cnt,
    output logic                 ts_sent_enough,
    output logic                 busy
);
    localparam int PW = $clog2(GEN1_PERIOD) + 1;
    // Bits [MAX_GEN:1] set, bit 0 and upper bits clear.
    localparam logic [7:0] RATE_MAP = 8'((1 << (MAX_GEN + 1)) - 2);

    typedef enum logic [1:0] {IDLE, SEND, PACE} state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            pace_q, pace_d;
    logic [PW-1:0]            period_q, period_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         target_q, target_d;
    logic                     enough_q, enough_d;
    logic [NUM_LANES-1:0]     lane_en_q, lane_en_d;
    logic [NUM_LANES*128-1:0] ts_q, ts_d;
    logic [NUM_LANES-1:0]     vld;
    logic [PW-1:0]            speed_period;
    logic                     accept;
    logic                     blocked;

    function automatic logic [127:0] build_ts(
        input logic [7:0] lane,
        input logic [7:0] link,
        input logic [7:0] info,
        input logic       ty
    );
        logic [127:0] t;
        t         = '0;
        t[7:0]    = 8'hBC;
        t[15:8]   = link;
        t[23:16]  = lane;
        t[31:24]  = info;
        t[39:32]  = RATE_MAP;
        for (int k = 6; k < 16; k++) begin
            t[8*k +: 8] = ty ? 8'h45 : 8'h4A;
        end
        return t;
    endfunction

    always_comb begin
        speed_period = PW'(GEN1_PERIOD);
        if (speed <= 3'd4) begin
            speed_period = PW'(GEN1_PERIOD) >> speed;
        end
    end

    // Stop beats update; an update with no lanes enabled is dropped.
    assign accept  = ts_update && !ts_stop && (lane_en != '0);
    // Lockstep: any enabled lane full stalls every lane.
    assign blocked = |(tx.tx_fifo_full & lane_en_q);

    always_comb begin
        ts_d = ts_q;
        if (accept) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                ts_d[128*i +: 128] = lane_en[i]
                    ? build_ts(8'(i), link_num, ts_info, ts_type)
                    : 128'd0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pace_d    = pace_q;
        period_d  = period_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        enough_d  = enough_q;
        lane_en_d = lane_en_q;
        vld       = '0;
        if (ts_stop) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d   = SEND;
            lane_en_d = lane_en;
            target_d  = sent_target;
            period_d  = speed_period;
            cnt_d     = '0;
            enough_d  = (sent_target == '0);
            pace_d    = '0;
        end else begin
            unique case (state_q)
                SEND: begin
                    if (!blocked) begin
                        vld = lane_en_q;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        enough_d = enough_q | (cnt_d >= target_q);
                        // A one-cycle period needs no PACE visit.
                        if (period_q > PW'(1)) begin
                            state_d = PACE;
                            pace_d  = period_q - PW'(2);
                        end
                    end
                end
                PACE: begin
                    if (pace_q == '0) begin
                        state_d = SEND;
                    end else begin
                        pace_d = pace_q - PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pace_q    <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            target_q  <= '0;
            enough_q  <= 1'b0;
            lane_en_q <= '0;
            ts_q      <= '0;
        end else begin
            state_q   <= state_d;
            pace_q    <= pace_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            enough_q  <= enough_d;
            lane_en_q <= lane_en_d;
            ts_q      <= ts_d;
        end
    end

    assign tx.ts_o         = ts_q;
    assign tx.ts_o_vld     = vld;
    assign ts_sent_cnt     = cnt_q;
    assign ts_sent_enough  = enough_q;
    assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_ts_gen_mlane.sv
// Self-checking bench for ts_gen_mlane: scoreboard of expected pulses
// (cycle + lane mask) plus inline checks of count, flag, busy and symbols.
module tb_ts_gen_mlane;
    localparam int NL = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    ts_info = 8'h00;
    logic          ts_type = 1'b0;
    logic [7:0]    link_num = 8'h00;
    logic [2:0]    speed = 3'd0;
    logic [NL-1:0] lane_en = '0;
    logic [CW-1:0] sent_target = '0;
    logic          ts_update = 1'b0;
    logic          ts_stop = 1'b0;
    logic [CW-1:0] ts_sent_cnt;
    logic          ts_sent_enough;
    logic          busy;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int            cyc;
        logic [NL-1:0] vld;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ts_gen_mlane_if #(.NUM_LANES(NL)) tx ();

    ts_gen_mlane #(
        .NUM_LANES(NL),
        .CNT_W(CW),
        .GEN1_PERIOD(64),
        .MAX_GEN(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ts_info(ts_info),
        .ts_type(ts_type),
        .link_num(link_num),
        .speed(speed),
        .lane_en(lane_en),
        .sent_target(sent_target),
        .ts_update(ts_update),
        .ts_stop(ts_stop),
        .tx(tx),
        .ts_sent_cnt(ts_sent_cnt),
        .ts_sent_enough(ts_sent_enough),
        .busy(busy)
    );

    function automatic logic [127:0] make_ts(input int lane, input logic [7:0] link,
                                             input logic [7:0] info, input logic ty);
        logic [127:0] v;
        v        = '0;
        v[7:0]   = 8'hBC;
        v[15:8]  = link;
        v[23:16] = 8'(lane);
        v[31:24] = info;
        v[39:32] = 8'h3E;
        for (int k = 6; k < 16; k++) v[8*k +: 8] = ty ? 8'h45 : 8'h4A;
        return v;
    endfunction

    // Scoreboard consumer: every pulse must match the next expected one.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && tx.ts_o_vld !== '0) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vld: got vld=%b at cycle %0d, required none",
                         tx.ts_o_vld, cyc);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL vld_cycle: got pulse at cycle %0d, required %0d", cyc, e.cyc);
                end
                n_chk++;
                if (tx.ts_o_vld !== e.vld) begin
                    n_fail++;
                    $display("FAIL vld_mask: got %b, required %b", tx.ts_o_vld, e.vld);
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go();
        ts_update = 1'b1;
        wait_cyc(cyc + 1);
        ts_update = 1'b0;
    endtask

    task automatic stop_at(input int c);
        wait_cyc(c);
        ts_stop = 1'b1;
        wait_cyc(c + 1);
        ts_stop = 1'b0;
    endtask

    task automatic push_train(input int first, input int per, input int n, input logic [NL-1:0] m);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc = first + k * per;
            e.vld = m;
            q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && q.size() != 0; i++) wait_cyc(cyc + 1);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pulses missing, required 0", name, q.size());
            q.delete();
        end
        wait_cyc(cyc + 70);
    endtask

    task automatic test_reset();
        wait_cyc(3);
        n_chk++;
        if (tx.ts_o !== '0) begin
            n_fail++; $display("FAIL reset_ts_o: got %h, required 0", tx.ts_o);
        end
        n_chk++;
        if (tx.ts_o_vld !== '0) begin
            n_fail++; $display("FAIL reset_vld: got %b, required 0", tx.ts_o_vld);
        end
        n_chk++;
        if (ts_sent_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d, required 0", ts_sent_cnt);
        end
        n_chk++;
        if (ts_sent_enough !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got enough=%b busy=%b, required 0 0", ts_sent_enough, busy);
        end
        rst = 1'b1;
        wait_cyc(cyc + 2);
    endtask

    task automatic test_gen1();
        int t;
        speed = 3'd0; lane_en = 4'hF; ts_type = 1'b0;
        link_num = 8'h05; ts_info = 8'h23; sent_target = 8'd100;
        t = cyc;
        push_train(t + 1, 64, 3, 4'hF);
        go();
        wait_cyc(t + 1);
        n_chk++;
        if (tx.ts_o[128*2 +: 128] !== make_ts(2, 8'h05, 8'h23, 1'b0)) begin
            n_fail++;
            $display("FAIL gen1_lane2: got %h, required %h", tx.ts_o[128*2 +: 128],
                     make_ts(2, 8'h05, 8'h23, 1'b0));
        end
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL gen1_busy: got %b, required 1", busy);
        end
        wait_cyc(t + 66);
        n_chk++;
        if (ts_sent_cnt !== 8'd2) begin
            n_fail++; $display("FAIL gen1_cnt2: got %0d, required 2", ts_sent_cnt);
        end
        stop_at(t + 130);
        drain("gen1");
        n_chk++;
        if (ts_sent_cnt !== 8'd3 || busy !== 1'b0 || ts_sent_enough !== 1'b0) begin
            n_fail++;
            $display("FAIL gen1_end: got cnt=%0d busy=%b enough=%b, required 3 0 0",
                     ts_sent_cnt, busy, ts_sent_enough);
        end
    endtask

    task automatic test_fast_enough();
        int t;
        speed = 3'd4; ts_type = 1'b1; sent_target = 8'd16; lane_en = 4'hF;
        t = cyc;
        push_train(t + 1, 4, 18, 4'hF);
        go();
        wait_cyc(t + 58);
        n_chk++;
        if (ts_sent_cnt !== 8'd15 || ts_sent_enough !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_15: got cnt=%0d enough=%b, required 15 0", ts_sent_cnt, ts_sent_enough);
        end
        wait_cyc(t + 62);
        n_chk++;
        if (ts_sent_cnt !== 8'd16 || ts_sent_enough !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_16: got cnt=%0d enough=%b, required 16 1", ts_sent_cnt, ts_sent_enough);
        end
        wait_cyc(t + 66);
        n_chk++;
        if (ts_sent_cnt !== 8'd17 || ts_sent_enough !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_17: got cnt=%0d enough=%b, required 17 1", ts_sent_cnt, ts_sent_enough);
        end
        n_chk++;
        if (tx.ts_o[128*1 +: 128] !== make_ts(1, 8'h05, 8'h23, 1'b1)) begin
            n_fail++;
            $display("FAIL fast_ts2: got %h, required %h", tx.ts_o[128*1 +: 128],
                     make_ts(1, 8'h05, 8'h23, 1'b1));
        end
        stop_at(t + 70);
        drain("fast");
    endtask

    task automatic test_lanes_full();
        int t;
        speed = 3'd4; ts_type = 1'b0; sent_target = 8'd255; lane_en = 4'b0101;
        tx.tx_fifo_full = 4'b0010;
        t = cyc;
        push_train(t + 1, 4, 2, 4'b0101);
        push_train(t + 19, 4, 1, 4'b0101);
        go();
        lane_en = 4'hF;
        wait_cyc(t + 2);
        n_chk++;
        if (tx.ts_o[128*1 +: 128] !== '0 || tx.ts_o[128*3 +: 128] !== '0) begin
            n_fail++;
            $display("FAIL lanes_disabled: got l1=%h l3=%h, required 0 0",
                     tx.ts_o[128*1 +: 128], tx.ts_o[128*3 +: 128]);
        end
        n_chk++;
        if (tx.ts_o[128*0 +: 128] !== make_ts(0, 8'h05, 8'h23, 1'b0)) begin
            n_fail++;
            $display("FAIL lanes_l0: got %h, required %h", tx.ts_o[128*0 +: 128],
                     make_ts(0, 8'h05, 8'h23, 1'b0));
        end
        wait_cyc(t + 9);
        tx.tx_fifo_full = 4'b0110;
        wait_cyc(t + 19);
        tx.tx_fifo_full = 4'b0010;
        stop_at(t + 20);
        drain("lanes");
        n_chk++;
        if (ts_sent_cnt !== 8'd3) begin
            n_fail++; $display("FAIL lanes_cnt: got %0d, required 3", ts_sent_cnt);
        end
        tx.tx_fifo_full = '0;
    endtask

    task automatic test_mid_update();
        int t;
        int t2;
        speed = 3'd0; lane_en = 4'hF; sent_target = 8'd1;
        t = cyc;
        push_train(t + 1, 64, 1, 4'hF);
        go();
        wait_cyc(t + 5);
        n_chk++;
        if (ts_sent_cnt !== 8'd1 || ts_sent_enough !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got cnt=%0d enough=%b, required 1 1", ts_sent_cnt, ts_sent_enough);
        end
        wait_cyc(t + 10);
        speed = 3'd2; sent_target = 8'd5;
        t2 = cyc;
        push_train(t2 + 1, 16, 3, 4'hF);
        go();
        wait_cyc(t2 + 2);
        n_chk++;
        if (ts_sent_cnt !== 8'd1 || ts_sent_enough !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_post: got cnt=%0d enough=%b, required 1 0", ts_sent_cnt, ts_sent_enough);
        end
        stop_at(t2 + 34);
        drain("mid");
    endtask

    task automatic test_stop_reset();
        int t;
        speed = 3'd0; lane_en = 4'hF; sent_target = 8'd100;
        t = cyc;
        push_train(t + 1, 64, 1, 4'hF);
        go();
        wait_cyc(t + 65);
        ts_stop = 1'b1; ts_update = 1'b1;
        wait_cyc(t + 66);
        ts_stop = 1'b0; ts_update = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || ts_sent_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL stop_held: got busy=%b cnt=%0d, required 0 1", busy, ts_sent_cnt);
        end
        drain("stop");
        t = cyc;
        push_train(t + 1, 64, 1, 4'hF);
        go();
        wait_cyc(t + 10);
        rst = 1'b0;
        #1;
        n_chk++;
        if (tx.ts_o !== '0 || tx.ts_o_vld !== '0 || ts_sent_cnt !== '0
            || ts_sent_enough !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got vld=%b cnt=%0d enough=%b busy=%b, required all 0",
                     tx.ts_o_vld, ts_sent_cnt, ts_sent_enough, busy);
        end
        wait_cyc(t + 12);
        rst = 1'b1;
        drain("rst");
    endtask

    task automatic test_speed7();
        int t;
        speed = 3'd7; lane_en = 4'hF; sent_target = 8'd0;
        t = cyc;
        push_train(t + 1, 64, 3, 4'hF);
        go();
        wait_cyc(t + 1);
        n_chk++;
        if (ts_sent_enough !== 1'b1) begin
            n_fail++; $display("FAIL target0_enough: got %b, required 1", ts_sent_enough);
        end
        stop_at(t + 130);
        drain("speed7");
    endtask

    task automatic test_saturate();
        int t;
        speed = 3'd4; lane_en = 4'hF; sent_target = 8'hFF;
        t = cyc;
        push_train(t + 1, 4, 258, 4'hF);
        go();
        wait_cyc(t + 1014);
        n_chk++;
        if (ts_sent_cnt !== 8'd254 || ts_sent_enough !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_254: got cnt=%0d enough=%b, required 254 0", ts_sent_cnt, ts_sent_enough);
        end
        wait_cyc(t + 1018);
        n_chk++;
        if (ts_sent_cnt !== 8'd255 || ts_sent_enough !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_255: got cnt=%0d enough=%b, required 255 1", ts_sent_cnt, ts_sent_enough);
        end
        wait_cyc(t + 1030);
        n_chk++;
        if (ts_sent_cnt !== 8'd255 || ts_sent_enough !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: got cnt=%0d enough=%b, required 255 1", ts_sent_cnt, ts_sent_enough);
        end
        stop_at(t + 1030);
        drain("sat");
    endtask

    initial begin
        tx.tx_fifo_full = '0;
        test_reset();
        test_gen1();
        test_fast_enough();
        test_lanes_full();
        test_mid_update();
        test_stop_reset();
        test_speed7();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
